// File: rtl/fu_dispatch_scheduler.sv
// Dispatch scheduler for the add and mul functional units of the Tomasulo core.
// Picks the oldest ready RS entry per class, times FU latency and arbitrates the single CDB.
module fu_dispatch_scheduler #(
    parameter int ROB_BITS = 3,
    parameter int ADD_LAT  = 2,
    parameter int MUL_LAT  = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                flush,
    input  logic [ROB_BITS-1:0] rob_head,
    input  logic [1:0]          add_rdy,
    input  logic [ROB_BITS-1:0] add_rob0,
    input  logic [ROB_BITS-1:0] add_rob1,
    input  logic [1:0]          mul_rdy,
    input  logic [ROB_BITS-1:0] mul_rob0,
    input  logic [ROB_BITS-1:0] mul_rob1,
    output logic [1:0]          add_grant,
    output logic [1:0]          mul_grant,
    output logic [ROB_BITS-1:0] add_fu_tag,
    output logic [ROB_BITS-1:0] mul_fu_tag,
    output logic                add_fu_busy,
    output logic                mul_fu_busy,
    output logic                cdb_valid,
    output logic [ROB_BITS-1:0] cdb_tag,
    output logic                cdb_src,
    output logic                add_free,
    output logic                mul_free,
    output logic [CNT_W-1:0]    cdb_conflicts
);

    localparam int LAT_MAX = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CW-1:0] ADD_M1 = CW'(ADD_LAT - 1);
    localparam logic [CW-1:0] MUL_M1 = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } fu_state_e;

    // Index 0 is the add unit, index 1 the mul unit throughout.
    fu_state_e           state_q [2];
    fu_state_e           state_d [2];
    logic [CW-1:0]       cnt_q   [2];
    logic [CW-1:0]       cnt_d   [2];
    logic [ROB_BITS-1:0] tag_q   [2];
    logic [ROB_BITS-1:0] tag_d   [2];
    logic [1:0]          grant_q [2];
    logic [1:0]          grant_d [2];
    logic [1:0]          busy_q;
    logic [1:0]          busy_d;
    logic [1:0]          free_q;
    logic [1:0]          free_d;
    logic                cdb_valid_q, cdb_valid_d;
    logic [ROB_BITS-1:0] cdb_tag_q, cdb_tag_d;
    logic                cdb_src_q, cdb_src_d;
    logic [CNT_W-1:0]    conf_q, conf_d;

    logic [1:0]          rdy      [2];
    logic [ROB_BITS-1:0] rob0     [2];
    logic [ROB_BITS-1:0] rob1     [2];
    logic [1:0]          sel      [2];
    logic [CW-1:0]       lat_m1   [2];
    logic [ROB_BITS-1:0] done_age [2];
    logic [1:0]          req;
    logic [1:0]          win;

    function automatic logic [1:0] pick_older(
        input logic [1:0]          r,
        input logic [ROB_BITS-1:0] t0,
        input logic [ROB_BITS-1:0] t1,
        input logic [ROB_BITS-1:0] head
    );
        logic [ROB_BITS-1:0] a0;
        logic [ROB_BITS-1:0] a1;
        a0 = t0 - head;
        a1 = t1 - head;
        // Equal ages cannot happen legally; entry 0 takes the tie.
        if (r == 2'b11) begin
            return (a1 < a0) ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    assign rdy[0]    = add_rdy;
    assign rdy[1]    = mul_rdy;
    assign rob0[0]   = add_rob0;
    assign rob0[1]   = mul_rob0;
    assign rob1[0]   = add_rob1;
    assign rob1[1]   = mul_rob1;
    assign lat_m1[0] = ADD_M1;
    assign lat_m1[1] = MUL_M1;

    assign sel[0] = pick_older(add_rdy, add_rob0, add_rob1, rob_head);
    assign sel[1] = pick_older(mul_rdy, mul_rob0, mul_rob1, rob_head);

    assign done_age[0] = tag_q[0] - rob_head;
    assign done_age[1] = tag_q[1] - rob_head;

    assign req[0] = (state_q[0] == S_DONE);
    assign req[1] = (state_q[1] == S_DONE);

    always_comb begin
        win    = req;
        conf_d = conf_q;
        if (req == 2'b11) begin
            win = (done_age[1] < done_age[0]) ? 2'b10 : 2'b01;
            if (conf_q != {CNT_W{1'b1}}) begin
                conf_d = conf_q + 1'b1;
            end
        end
    end

    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;
        free_d      = 2'b00;
        busy_d      = 2'b00;
        for (int u = 0; u < 2; u++) begin
            state_d[u] = state_q[u];
            cnt_d[u]   = cnt_q[u];
            tag_d[u]   = tag_q[u];
            grant_d[u] = 2'b00;
        end

        for (int u = 0; u < 2; u++) begin
            case (state_q[u])
                S_IDLE: begin
                    if (rdy[u] != 2'b00) begin
                        grant_d[u] = sel[u];
                        tag_d[u]   = sel[u][1] ? rob1[u] : rob0[u];
                        state_d[u] = S_EXEC;
                        cnt_d[u]   = lat_m1[u];
                    end
                end
                S_EXEC: begin
                    if (cnt_q[u] == '0) begin
                        state_d[u] = S_DONE;
                    end else begin
                        cnt_d[u] = cnt_q[u] - 1'b1;
                    end
                end
                S_DONE: begin
                    if (win[u]) begin
                        state_d[u]  = S_IDLE;
                        cdb_valid_d = 1'b1;
                        cdb_tag_d   = tag_q[u];
                        cdb_src_d   = (u == 1);
                        free_d[u]   = 1'b1;
                    end
                end
                default: state_d[u] = S_IDLE;
            endcase
        end

        // A squash discards everything in flight, including this edge's dispatch and writeback.
        if (flush) begin
            cdb_valid_d = 1'b0;
            free_d      = 2'b00;
            for (int u = 0; u < 2; u++) begin
                state_d[u] = S_IDLE;
                cnt_d[u]   = '0;
                tag_d[u]   = '0;
                grant_d[u] = 2'b00;
            end
        end

        for (int u = 0; u < 2; u++) begin
            busy_d[u] = (state_d[u] != S_IDLE);
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                state_q[u] <= S_IDLE;
                cnt_q[u]   <= '0;
                tag_q[u]   <= '0;
                grant_q[u] <= 2'b00;
            end
            busy_q      <= 2'b00;
            free_q      <= 2'b00;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= 1'b0;
            conf_q      <= '0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                state_q[u] <= state_d[u];
                cnt_q[u]   <= cnt_d[u];
                tag_q[u]   <= tag_d[u];
                grant_q[u] <= grant_d[u];
            end
            busy_q      <= busy_d;
            free_q      <= free_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
            conf_q      <= flush ? conf_q : conf_d;
        end
    end

    assign add_grant     = grant_q[0];
    assign mul_grant     = grant_q[1];
    assign add_fu_tag    = tag_q[0];
    assign mul_fu_tag    = tag_q[1];
    assign add_fu_busy   = busy_q[0];
    assign mul_fu_busy   = busy_q[1];
    assign add_free      = free_q[0];
    assign mul_free      = free_q[1];
    assign cdb_valid     = cdb_valid_q;
    assign cdb_tag       = cdb_tag_q;
    assign cdb_src       = cdb_src_q;
    assign cdb_conflicts = conf_q;

endmodule
